// File: rtl/ds_compact_if.sv
// Video in/out bundle for ds_compact; o_ovf exists only when DS_COMPACT_OVF_EN is defined.
interface ds_compact_if #(
  parameter int unsigned WIDTH = 10
);
  logic             i_vsync;
  logic             i_hsync;
  logic             i_de;
  logic [WIDTH-1:0] i_r_data;
  logic [WIDTH-1:0] i_g_data;
  logic [WIDTH-1:0] i_b_data;
  logic             o_vsync;
  logic             o_hsync;
  logic             o_de;
  logic [WIDTH-1:0] o_r_data;
  logic [WIDTH-1:0] o_g_data;
  logic [WIDTH-1:0] o_b_data;
`ifdef DS_COMPACT_OVF_EN
  logic             o_ovf;

  modport master (
    output i_vsync, i_hsync, i_de, i_r_data, i_g_data, i_b_data,
    input  o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_ovf
  );
  modport slave (
    input  i_vsync, i_hsync, i_de, i_r_data, i_g_data, i_b_data,
    output o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_ovf
  );
`else
  modport master (
    output i_vsync, i_hsync, i_de, i_r_data, i_g_data, i_b_data,
    input  o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data
  );
  modport slave (
    input  i_vsync, i_hsync, i_de, i_r_data, i_g_data, i_b_data,
    output o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data
  );
`endif
endinterface

// File: rtl/ds_compact.sv
// Line compactor: ping-pong line buffer written from sparse i_de, replayed as a
// contiguous burst after HBP back-porch cycles. DS_COMPACT_OVF_EN adds sticky o_ovf.
module ds_compact #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned HACT  = 10,
  parameter int unsigned HBP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  ds_compact_if.slave vif
);
  localparam int unsigned OACT = HACT / 2;
  localparam int unsigned DW   = 3 * WIDTH;
  localparam int unsigned PW   = $clog2(OACT + 1);
  localparam int unsigned AW   = (OACT > 1) ? $clog2(OACT) : 1;
  localparam int unsigned CW   = (HBP > 1) ? $clog2(HBP) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, ACTIVE = 2'd2} state_t;

  logic [DW-1:0] mem [2][OACT];

  logic          de_q, vsync_q;
  logic          wr_bank, rd_bank;
  logic [PW-1:0] wr_ptr;
  logic          drop_q;
  logic [1:0]    full;
  logic [PW-1:0] count [2];

  state_t        state, state_d;
  logic [CW-1:0] pre_cnt, pre_d;
  logic [PW-1:0] rd_idx, idx_d;
  logic          hsync_d, de_d, rd_done;
  logic [DW-1:0] pix_d;

  logic          o_vsync_q, o_hsync_q, o_de_q;
  logic [DW-1:0] o_pix_q;

  logic vsync_rise, line_start, line_end, drop_now, wr_en, eol_commit;

  // i_hsync carries no information here; line boundaries come from i_de alone
  logic unused_hsync;
  assign unused_hsync = vif.i_hsync;

  assign vsync_rise = vif.i_vsync & ~vsync_q;
  assign line_start = vif.i_de & ~de_q;
  assign line_end   = ~vif.i_de & de_q;
  // Drop verdict is taken on the first pixel and held for the rest of the line
  assign drop_now   = line_start ? full[wr_bank] : drop_q;
  assign wr_en      = ~vsync_rise & vif.i_de & ~drop_now & (wr_ptr < PW'(OACT));
  assign eol_commit = ~vsync_rise & line_end & (wr_ptr != '0) & ~drop_q;

  // Write side: pointer, bank select, per-bank full flag and pixel count
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q      <= 1'b0;
      vsync_q   <= 1'b0;
      o_vsync_q <= 1'b0;
      wr_bank   <= 1'b0;
      wr_ptr    <= '0;
      drop_q    <= 1'b0;
      full      <= '0;
      count[0]  <= '0;
      count[1]  <= '0;
    end else begin
      de_q      <= vif.i_de;
      vsync_q   <= vif.i_vsync;
      o_vsync_q <= vif.i_vsync;
      if (vsync_rise) begin
        wr_bank <= 1'b0;
        wr_ptr  <= '0;
        drop_q  <= 1'b0;
      end else begin
        if (line_start) drop_q <= drop_now;
        if (eol_commit) begin
          count[wr_bank] <= wr_ptr;
          wr_bank        <= ~wr_bank;
          wr_ptr         <= '0;
        end else if (wr_en) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
      end
      // Set and clear can land together only on opposite banks
      for (int b = 0; b < 2; b++) begin
        if (vsync_rise)                           full[b] <= 1'b0;
        else if (eol_commit && wr_bank == 1'(b))  full[b] <= 1'b1;
        else if (rd_done && rd_bank == 1'(b))     full[b] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_ptr[AW-1:0]] <= {vif.i_r_data, vif.i_g_data, vif.i_b_data};
  end

  // Read FSM next state and next registered outputs
  always_comb begin
    state_d = state;
    pre_d   = pre_cnt;
    idx_d   = rd_idx;
    hsync_d = 1'b0;
    de_d    = 1'b0;
    rd_done = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_d = PRE;
          pre_d   = '0;
          hsync_d = 1'b1;
        end
      end
      PRE: begin
        if (pre_cnt == CW'(HBP - 1)) begin
          state_d = ACTIVE;
          idx_d   = '0;
          de_d    = 1'b1;
        end else begin
          pre_d = pre_cnt + CW'(1);
        end
      end
      ACTIVE: begin
        if (rd_idx == count[rd_bank] - PW'(1)) begin
          state_d = IDLE;
          rd_done = 1'b1;
        end else begin
          idx_d = rd_idx + PW'(1);
          de_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (vsync_rise) begin
      state_d = IDLE;
      hsync_d = 1'b0;
      de_d    = 1'b0;
      rd_done = 1'b0;
    end
  end

  assign pix_d = de_d ? mem[rd_bank][idx_d[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      rd_idx    <= '0;
      rd_bank   <= 1'b0;
      o_hsync_q <= 1'b0;
      o_de_q    <= 1'b0;
      o_pix_q   <= '0;
    end else begin
      state     <= state_d;
      pre_cnt   <= pre_d;
      rd_idx    <= idx_d;
      o_hsync_q <= hsync_d;
      o_de_q    <= de_d;
      o_pix_q   <= pix_d;
      if (vsync_rise)   rd_bank <= 1'b0;
      else if (rd_done) rd_bank <= ~rd_bank;
    end
  end

`ifdef DS_COMPACT_OVF_EN
  logic ovf_q;

  // Sticky overflow: set by a dropped line's first pixel, cleared by frame resync
  always_ff @(posedge clk) begin
    if (rst)                                 ovf_q <= 1'b0;
    else if (vsync_rise)                     ovf_q <= 1'b0;
    else if (line_start && full[wr_bank])    ovf_q <= 1'b1;
  end

  assign vif.o_ovf = ovf_q;
`endif

  assign vif.o_vsync  = o_vsync_q;
  assign vif.o_hsync  = o_hsync_q;
  assign vif.o_de     = o_de_q;
  assign vif.o_r_data = o_pix_q[DW-1 -: WIDTH];
  assign vif.o_g_data = o_pix_q[2*WIDTH-1 -: WIDTH];
  assign vif.o_b_data = o_pix_q[WIDTH-1:0];
endmodule

// File: tb/tb_ds_compact.sv
// Bench for ds_compact: line-level reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ds_compact;
  localparam int unsigned W    = 10;
  localparam int unsigned OACT = 5;
  localparam int unsigned HBP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ds_compact_if #(.WIDTH(W)) vif ();

  ds_compact #(.WIDTH(W), .HACT(10), .HBP(HBP)) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int de_cnt   = 0;
  logic [W-1:0] burst_r [8];
  int burst_len;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: stored lines per bank, and the read burst described as a
  // time offset t from its hsync (t<HBP back porch, then count data cycles).
  logic [29:0] m_bank [2][OACT];
  bit   m_full [2];
  int   m_cnt  [2];
  int   m_wr_bank, m_rd_bank, m_wr_ptr, m_t, m_clr_b;
  bit   m_drop, m_de_q, m_vs_q, m_busy, m_ovf, m_ls, m_eol, m_dn, m_clr;
  bit   e_vsync, e_hsync, e_de, e_ovf;
  logic [29:0] e_pix;

  always @(posedge clk) begin
    if (rst) begin
      m_full = '{0, 0}; m_cnt = '{0, 0};
      m_wr_bank = 0; m_rd_bank = 0; m_wr_ptr = 0; m_t = 0;
      m_drop = 0; m_de_q = 0; m_vs_q = 0; m_busy = 0; m_ovf = 0;
      e_vsync = 0; e_hsync = 0; e_de = 0; e_pix = '0; e_ovf = 0;
    end else begin
      e_vsync = vif.i_vsync;
      e_hsync = 0; e_de = 0; e_pix = '0;
      if (vif.i_vsync && !m_vs_q) begin
        m_full = '{0, 0};
        m_wr_bank = 0; m_rd_bank = 0; m_wr_ptr = 0;
        m_drop = 0; m_ovf = 0; m_busy = 0;
      end else begin
        m_clr = 0;
        if (m_busy) begin
          m_t++;
          if (m_t >= int'(HBP) && m_t < int'(HBP) + m_cnt[m_rd_bank]) begin
            e_de  = 1;
            e_pix = m_bank[m_rd_bank][m_t - int'(HBP)];
          end else if (m_t >= int'(HBP)) begin
            m_busy = 0; m_clr = 1; m_clr_b = m_rd_bank;
            m_rd_bank = 1 - m_rd_bank;
          end
        end else if (m_full[m_rd_bank]) begin
          m_busy = 1; m_t = 0; e_hsync = 1;
        end
        m_ls  = vif.i_de && !m_de_q;
        m_eol = !vif.i_de && m_de_q;
        m_dn  = m_ls ? m_full[m_wr_bank] : m_drop;
        if (m_ls && m_dn) m_ovf = 1;
        if (vif.i_de && !m_dn && m_wr_ptr < int'(OACT)) begin
          m_bank[m_wr_bank][m_wr_ptr] = {vif.i_r_data, vif.i_g_data, vif.i_b_data};
          m_wr_ptr++;
        end
        m_drop = m_dn;
        if (m_clr) m_full[m_clr_b] = 0;
        if (m_eol && m_wr_ptr > 0 && !m_drop) begin
          m_full[m_wr_bank] = 1;
          m_cnt[m_wr_bank]  = m_wr_ptr;
          m_wr_bank = 1 - m_wr_bank;
          m_wr_ptr  = 0;
        end
      end
      m_de_q = vif.i_de;
      m_vs_q = vif.i_vsync;
      e_ovf  = m_ovf;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_vsync", 32'(vif.o_vsync), 32'(e_vsync));
      check("o_hsync", 32'(vif.o_hsync), 32'(e_hsync));
      check("o_de",    32'(vif.o_de),    32'(e_de));
      check("o_r",     32'(vif.o_r_data), 32'(e_pix[29:20]));
      check("o_g",     32'(vif.o_g_data), 32'(e_pix[19:10]));
      check("o_b",     32'(vif.o_b_data), 32'(e_pix[9:0]));
`ifdef DS_COMPACT_OVF_EN
      check("o_ovf",   32'(vif.o_ovf),   32'(e_ovf));
`endif
    end
  end

  always @(negedge clk) if (vif.o_de === 1'b1) de_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
    vif.i_hsync = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_line(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      vif.i_de = 1'b1;
      if (rnd) begin
        vif.i_r_data = W'($urandom); vif.i_g_data = W'($urandom); vif.i_b_data = W'($urandom);
      end else begin
        vif.i_r_data = W'(base + i); vif.i_g_data = W'(base + i + 100); vif.i_b_data = W'(base + i + 200);
      end
      tick();
    end
    vif.i_de = 1'b0;
    vif.i_r_data = '0; vif.i_g_data = '0; vif.i_b_data = '0;
  endtask

  task automatic wait_de(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vif.o_de === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_de: no o_de within 60 cycles, required o_de=1");
    end
  endtask

  task automatic get_burst();
    bit ok;
    burst_len = 0;
    wait_de(ok);
    if (ok) begin
      while (vif.o_de === 1'b1 && burst_len < 8) begin
        burst_r[burst_len] = vif.o_r_data;
        burst_len++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    bit ok;
    vif.i_vsync = 0; vif.i_hsync = 0; vif.i_de = 0;
    vif.i_r_data = '0; vif.i_g_data = '0; vif.i_b_data = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_de", 32'(vif.o_de), 0);
    check("reset_hsync", 32'(vif.o_hsync), 0);
    repeat (3) tick();

    // Five pixels R=1..5: hsync one cycle after de-fall, burst two cycles later
    drive_line(5, 1, 0);
    @(negedge clk);
    @(negedge clk);
    check("t1_hsync_eol", 32'(vif.o_hsync), 0);
    @(negedge clk);
    check("t1_hsync", 32'(vif.o_hsync), 1);
    check("t1_de_pre0", 32'(vif.o_de), 0);
    @(negedge clk);
    check("t1_hsync_pre1", 32'(vif.o_hsync), 0);
    check("t1_de_pre1", 32'(vif.o_de), 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("t1_de", 32'(vif.o_de), 1);
      check("t1_r", 32'(vif.o_r_data), 32'(i));
    end
    @(negedge clk);
    check("t1_de_end", 32'(vif.o_de), 0);
    check("t1_r_end", 32'(vif.o_r_data), 0);
    repeat (4) tick();

    // Seven pixels: only the first five survive
    drive_line(7, 11, 0);
    tick();
    get_burst();
    check("t2_len", 32'(burst_len), 5);
    for (int i = 0; i < 5; i++) check("t2_r", 32'(burst_r[i]), 32'(11 + i));
    repeat (4) tick();

    // Three pixels: three-cycle burst
    drive_line(3, 30, 0);
    tick();
    get_burst();
    check("t3_len", 32'(burst_len), 3);
    check("t3_r0", 32'(burst_r[0]), 30);
    check("t3_r2", 32'(burst_r[2]), 32);
    repeat (4) tick();

    // Three back-to-back lines: third finds its bank still full and is dropped
    de_cnt = 0;
    drive_line(4, 70, 0); tick();
    drive_line(4, 80, 0); tick();
    drive_line(4, 90, 0);
    repeat (30) tick();
    check("t4_de_cycles", 32'(de_cnt), 8);
`ifdef DS_COMPACT_OVF_EN
    check("t4_ovf_set", 32'(vif.o_ovf), 1);
`endif
    vif.i_vsync = 1'b1; tick();
    vif.i_vsync = 1'b0; tick();
    @(negedge clk);
`ifdef DS_COMPACT_OVF_EN
    check("t4_ovf_clr", 32'(vif.o_ovf), 0);
`endif
    repeat (3) tick();

    // vsync rise mid-burst aborts it; the following line uses bank 0 again
    drive_line(5, 20, 0);
    tick();
    wait_de(ok);
    vif.i_vsync = 1'b1;
    @(negedge clk);
    check("t5_abort_de", 32'(vif.o_de), 0);
    tick();
    vif.i_vsync = 1'b0;
    repeat (3) tick();
    drive_line(2, 40, 0);
    tick();
    get_burst();
    check("t5_len", 32'(burst_len), 2);
    check("t5_r0", 32'(burst_r[0]), 40);
    check("t5_r1", 32'(burst_r[1]), 41);
    repeat (4) tick();

    // Reset mid-burst: outputs clear at once, next line plays normally
    drive_line(5, 50, 0);
    tick();
    wait_de(ok);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_de", 32'(vif.o_de), 0);
    check("t6_rst_r", 32'(vif.o_r_data), 0);
    check("t6_rst_hsync", 32'(vif.o_hsync), 0);
    rst = 1'b0;
    repeat (2) tick();
    drive_line(3, 60, 0);
    tick();
    get_burst();
    check("t6_len", 32'(burst_len), 3);
    check("t6_r0", 32'(burst_r[0]), 60);
    check("t6_r2", 32'(burst_r[2]), 62);
    repeat (4) tick();

    // Random lines, gaps and frame resyncs, checked by the model each cycle
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        vif.i_vsync = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        vif.i_vsync = 1'b0;
        tick();
      end else begin
        drive_line(int'($urandom_range(0, 8)), 0, 1);
        repeat ($urandom_range(1, 12)) tick();
      end
    end
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
